// File: rtl/crc_generator.sv
// Byte-serial Ethernet CRC-32 (IEEE 802.3, reflected poly 0xEDB88320).
// Folds one byte per clock while crc_en is high and finalizes on the first
// low cycle. The finalized value and the done flag are held until the next
// frame starts.
module crc_generator #(
  parameter bit OUT_BYTE_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        crc_en,
  output logic [31:0] crc_out,
  output logic        crc_done
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;
  logic [31:0] r_crc_out;
  logic [31:0] w_crc_out_next;
  logic        r_done;
  logic        w_done_next;

  logic [31:0] w_final;
  logic [31:0] w_swapped;
  logic [31:0] w_final_out;
  logic [31:0] w_upd_init;
  logic [31:0] w_upd_run;

  // Eight LSB-first bit steps unrolled into a single combinational update.
  function automatic logic [31:0] crc_update_byte(input logic [31:0] c_in,
                                                  input logic [7:0]  d_in);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d_in[i];
      c  = (c >> 1) ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  assign w_upd_init = crc_update_byte(CRC_INIT, data_in);
  assign w_upd_run  = crc_update_byte(r_crc, data_in);

  // Final XOR, then optional byte reversal so [31:24] is the first wire byte.
  assign w_final = ~r_crc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign w_swapped[8*gi +: 8] = w_final[8*(3-gi) +: 8];
    end
  endgenerate

  assign w_final_out = OUT_BYTE_SWAP ? w_swapped : w_final;

  // State, running CRC and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_crc     <= CRC_INIT;
      r_crc_out <= 32'h0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_crc     <= w_crc_next;
      r_crc_out <= w_crc_out_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic: start a frame, accumulate bytes, finalize on crc_en low.
  always_comb begin
    w_state_next   = r_state;
    w_crc_next     = r_crc;
    w_crc_out_next = r_crc_out;
    w_done_next    = r_done;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (crc_en) begin
          // A new frame restarts from the seed; a byte valid on this same
          // cycle is already part of the frame.
          w_state_next = S_ACCUM;
          w_done_next  = 1'b0;
          w_crc_next   = data_valid ? w_upd_init : CRC_INIT;
        end
      end
      S_ACCUM: begin
        if (crc_en) begin
          if (data_valid) begin
            w_crc_next = w_upd_run;
          end
        end else begin
          // data_valid is deliberately ignored in the finalizing cycle.
          w_state_next   = S_DONE;
          w_crc_out_next = w_final_out;
          w_done_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_crc_next   = CRC_INIT;
      end
    endcase
  end

  assign crc_out  = r_crc_out;
  assign crc_done = r_done;

endmodule

// File: tb/tb_crc_generator.sv
// Bench for crc_generator: two instances (plain and byte-swapped output)
// share one stimulus stream; expectations come from fixed reference values
// and a table-driven CRC-32 model over the queued frame bytes.
module tb_crc_generator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        crc_en;
  logic [31:0] crc_out0;
  logic        crc_done0;
  logic [31:0] crc_out1;
  logic        crc_done1;

  int n_vec;
  int n_err;

  logic [7:0]  frame_q[$];
  logic [31:0] crc_table[256];

  crc_generator #(.OUT_BYTE_SWAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .crc_en(crc_en), .crc_out(crc_out0), .crc_done(crc_done0)
  );

  crc_generator #(.OUT_BYTE_SWAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .crc_en(crc_en), .crc_out(crc_out1), .crc_done(crc_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void build_table();
    logic [31:0] v;
    for (int n = 0; n < 256; n++) begin
      v = 32'(n);
      for (int k = 0; k < 8; k++)
        v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_table[n] = v;
    end
  endfunction

  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFFFFFF;
    foreach (frame_q[n]) begin
      idx = c[7:0] ^ frame_q[n];
      c   = (c >> 8) ^ crc_table[idx];
    end
    return ~c;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic void load_check_string();
    frame_q.delete();
    for (int n = 0; n < 9; n++) frame_q.push_back(8'h31 + 8'(n));
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams frame_q with crc_en high and random idle gaps of up to gap_max
  // cycles before each byte; an empty queue still gets one enabled cycle.
  task automatic drive_frame(input int gap_max);
    int gaps;
    crc_en = 1'b1;
    if (frame_q.size() == 0) begin
      data_valid = 1'b0;
      data_in    = 8'($urandom);
      step();
    end
    foreach (frame_q[n]) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        step();
      end
      data_valid = 1'b1;
      data_in    = frame_q[n];
      step();
    end
    data_valid = 1'b0;
  endtask

  // One low crc_en cycle with junk data_valid that must be ignored.
  task automatic finalize();
    crc_en     = 1'b0;
    data_valid = 1'($urandom);
    data_in    = 8'($urandom);
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; crc_en = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    #2;
    n_vec++;
    if (crc_out0 !== 32'h0 || crc_done0 !== 1'b0 || crc_out1 !== 32'h0 || crc_done1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: out0=%h done0=%b out1=%h done1=%b, want 0/0", crc_out0, crc_done0, crc_out1, crc_done1);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (crc_out0 !== 32'h0 || crc_done0 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: out0=%h done0=%b, want 0/0", crc_out0, crc_done0);
    end
    $display("test_reset done");
  endtask

  task automatic test_check_string();
    load_check_string();
    drive_frame(0);
    n_vec++;
    if (crc_done0 !== 1'b0) begin
      n_err++;
      $display("FAIL check_done_before_final: done0=%b, want 0", crc_done0);
    end
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'hCBF43926) begin
      n_err++;
      $display("FAIL check_string: out0=%h done0=%b, want cbf43926/1", crc_out0, crc_done0);
    end
    n_vec++;
    if (crc_done1 !== 1'b1 || crc_out1 !== 32'h2639F4CB) begin
      n_err++;
      $display("FAIL check_string_swap: out1=%h done1=%b, want 2639f4cb/1", crc_out1, crc_done1);
    end
    $display("test_check_string: out0=%h out1=%h", crc_out0, crc_out1);
  endtask

  task automatic test_single_bytes();
    logic [7:0]  bytes[2];
    logic [31:0] want[2];
    bytes[0] = 8'h61; want[0] = 32'hE8B7BE43;
    bytes[1] = 8'h00; want[1] = 32'hD202EF8D;
    for (int t = 0; t < 2; t++) begin
      frame_q.delete();
      frame_q.push_back(bytes[t]);
      drive_frame(0);
      finalize();
      n_vec++;
      if (crc_done0 !== 1'b1 || crc_out0 !== want[t]) begin
        n_err++;
        $display("FAIL single_byte_%h: out0=%h done0=%b, want %h/1", bytes[t], crc_out0, crc_done0, want[t]);
      end
      n_vec++;
      if (crc_out1 !== bswap(want[t])) begin
        n_err++;
        $display("FAIL single_byte_swap_%h: out1=%h, want %h", bytes[t], crc_out1, bswap(want[t]));
      end
      $display("test_single_bytes: byte=%h out0=%h", bytes[t], crc_out0);
      finalize();
    end
  endtask

  // Gapped frame; crc_out must keep the previous result throughout.
  task automatic test_gaps();
    logic [31:0] prev;
    int gaps;
    prev = crc_out0;
    load_check_string();
    crc_en = 1'b1;
    foreach (frame_q[n]) begin
      gaps = int'($urandom_range(1, 3));
      repeat (gaps) begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        step();
      end
      data_valid = 1'b1;
      data_in    = frame_q[n];
      step();
      n_vec++;
      if (crc_out0 !== prev || crc_done0 !== 1'b0) begin
        n_err++;
        $display("FAIL gaps_hold_byte%0d: out0=%h done0=%b, want %h/0", n, crc_out0, crc_done0, prev);
      end
    end
    data_valid = 1'b0;
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'hCBF43926) begin
      n_err++;
      $display("FAIL gaps_result: out0=%h done0=%b, want cbf43926/1", crc_out0, crc_done0);
    end
    $display("test_gaps: out0=%h", crc_out0);
  endtask

  task automatic test_empty();
    crc_en = 1'b1; data_valid = 1'b0;
    step(); step();
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'h0 || crc_out1 !== 32'h0) begin
      n_err++;
      $display("FAIL empty_frame: out0=%h out1=%h done0=%b, want 0/0/1", crc_out0, crc_out1, crc_done0);
    end
    for (int n = 0; n < 4; n++) begin
      crc_en = 1'b0; data_valid = 1'b1; data_in = 8'($urandom);
      step();
      n_vec++;
      if (crc_done0 !== 1'b1 || crc_out0 !== 32'h0) begin
        n_err++;
        $display("FAIL empty_hold_%0d: out0=%h done0=%b, want 0/1", n, crc_out0, crc_done0);
      end
    end
    data_valid = 1'b0;
    $display("test_empty: out0=%h done0=%b", crc_out0, crc_done0);
  endtask

  task automatic test_reset_mid_frame();
    load_check_string();
    crc_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      data_valid = 1'b1; data_in = frame_q[n];
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (crc_out0 !== 32'h0 || crc_done0 !== 1'b0 || crc_out1 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_frame: out0=%h out1=%h done0=%b, want 0/0/0", crc_out0, crc_out1, crc_done0);
    end
    crc_en = 1'b0; data_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive_frame(0);
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'hCBF43926) begin
      n_err++;
      $display("FAIL after_reset_frame: out0=%h done0=%b, want cbf43926/1", crc_out0, crc_done0);
    end
    $display("test_reset_mid_frame: out0=%h", crc_out0);
  endtask

  task automatic test_back_to_back();
    frame_q.delete();
    frame_q.push_back(8'h61);
    drive_frame(0);
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'hE8B7BE43) begin
      n_err++;
      $display("FAIL b2b_first: out0=%h done0=%b, want e8b7be43/1", crc_out0, crc_done0);
    end
    load_check_string();
    crc_en = 1'b1; data_valid = 1'b1; data_in = frame_q[0];
    step();
    n_vec++;
    if (crc_done0 !== 1'b0 || crc_out0 !== 32'hE8B7BE43) begin
      n_err++;
      $display("FAIL b2b_restart: out0=%h done0=%b, want e8b7be43/0", crc_out0, crc_done0);
    end
    void'(frame_q.pop_front());
    drive_frame(0);
    finalize();
    n_vec++;
    if (crc_done0 !== 1'b1 || crc_out0 !== 32'hCBF43926 || crc_out1 !== 32'h2639F4CB) begin
      n_err++;
      $display("FAIL b2b_second: out0=%h out1=%h done0=%b, want cbf43926/2639f4cb/1", crc_out0, crc_out1, crc_done0);
    end
    $display("test_back_to_back: out0=%h", crc_out0);
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int len;
    int idle;
    for (int f = 0; f < 25; f++) begin
      frame_q.delete();
      len = int'($urandom_range(0, 20));
      for (int n = 0; n < len; n++) frame_q.push_back(8'($urandom));
      exp = model_crc();
      drive_frame(f % 3);
      finalize();
      n_vec++;
      if (crc_done0 !== 1'b1 || crc_out0 !== exp || crc_out1 !== bswap(exp)) begin
        n_err++;
        $display("FAIL random_frame_%0d: len=%0d out0=%h out1=%h done0=%b, want %h/%h/1",
                 f, len, crc_out0, crc_out1, crc_done0, exp, bswap(exp));
      end
      idle = int'($urandom_range(0, 3));
      repeat (idle) begin
        crc_en = 1'b0; data_valid = 1'($urandom); data_in = 8'($urandom);
        step();
        n_vec++;
        if (crc_done0 !== 1'b1 || crc_out0 !== exp) begin
          n_err++;
          $display("FAIL random_hold_%0d: out0=%h done0=%b, want %h/1", f, crc_out0, crc_done0, exp);
        end
      end
      $display("test_random: frame=%0d len=%0d out0=%h", f, len, crc_out0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    build_table();
    test_reset();
    test_check_string();
    test_single_bytes();
    test_gaps();
    test_empty();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
